// File: rtl/icb_arbt_2m1s_pkg.sv
// Shared constants and types for the two-master ICB arbiter: bus widths,
// master ids and the arbiter's lock-state/debug types.
package icb_arbt_2m1s_pkg;

  localparam int ICB_ADW = 32;
  localparam int ICB_DW  = 64;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    arb_state_e state;
    logic       gnt_vld;
    logic       gnt_id;
    logic       rr_last;
  } arb_dbg_t;

endpackage

// File: rtl/icb_arbt_2m1s_if.sv
// One ICB link (command + response channels). The master modport drives
// commands and consumes responses; the slave modport does the opposite.
interface icb_arbt_2m1s_if #(
  parameter int ADW = 32,
  parameter int DW  = 64
);
  // Both channels: a beat transfers on a cycle where valid & ready are high.
  // Once valid is raised, valid and payload hold until that transfer happens.
  logic            cmd_valid;
  logic            cmd_ready;
  logic [ADW-1:0]  cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/icb_outs_fifo.sv
// In-order tracker of outstanding commands: stores the 1-bit master id of
// every accepted command so responses can be steered back in order.
module icb_outs_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/icb_arbt_2m1s.sv
// Two-master, one-slave ICB arbiter: round-robin command grant held until
// handshake, zero-latency command pass-through, in-order response steering.
module icb_arbt_2m1s
  import icb_arbt_2m1s_pkg::*;
#(
  parameter int ADW        = ICB_ADW,
  parameter int DW         = ICB_DW,
  parameter int OUTS_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  icb_arbt_2m1s_if.slave          m0_icb,
  icb_arbt_2m1s_if.slave          m1_icb,
  icb_arbt_2m1s_if.master         s_icb,
  output arb_dbg_t                dbg_o
);

  arb_state_e state_q, state_d;
  logic       lock_id_q, lock_id_d;
  logic       rr_last_q, rr_last_d;
  logic       gnt_vld, gnt_id, gnt_req;
  logic       s_cmd_valid, cmd_hs;
  logic       full, empty, head;
  logic       s_rsp_ready, rsp_hs;

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_last_d = rr_last_q;
    gnt_vld   = 1'b0;
    gnt_id    = MID_IFU;
    if (state_q == ARB_LOCK) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id_q;
    end else if (m0_icb.cmd_valid && m1_icb.cmd_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = ~rr_last_q;
    end else if (m0_icb.cmd_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = MID_IFU;
    end else if (m1_icb.cmd_valid) begin
      gnt_vld = 1'b1;
      gnt_id  = MID_LSU;
    end
    gnt_req     = (gnt_id == MID_LSU) ? m1_icb.cmd_valid : m0_icb.cmd_valid;
    s_cmd_valid = gnt_vld & gnt_req & ~full;
    cmd_hs      = s_cmd_valid & s_icb.cmd_ready;
    // A presented-but-stalled command pins the grant so the slave sees a stable payload.
    if (cmd_hs) begin
      state_d   = ARB_IDLE;
      rr_last_d = gnt_id;
    end else if (s_cmd_valid) begin
      state_d   = ARB_LOCK;
      lock_id_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= MID_IFU;
      rr_last_q <= MID_LSU;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign s_icb.cmd_valid = s_cmd_valid;
  assign s_icb.cmd_addr  = !gnt_vld ? '0 : (gnt_id ? m1_icb.cmd_addr  : m0_icb.cmd_addr);
  assign s_icb.cmd_read  = !gnt_vld ? '0 : (gnt_id ? m1_icb.cmd_read  : m0_icb.cmd_read);
  assign s_icb.cmd_wdata = !gnt_vld ? '0 : (gnt_id ? m1_icb.cmd_wdata : m0_icb.cmd_wdata);
  assign s_icb.cmd_wmask = !gnt_vld ? '0 : (gnt_id ? m1_icb.cmd_wmask : m0_icb.cmd_wmask);

  assign m0_icb.cmd_ready = gnt_vld & (gnt_id == MID_IFU) & ~full & s_icb.cmd_ready;
  assign m1_icb.cmd_ready = gnt_vld & (gnt_id == MID_LSU) & ~full & s_icb.cmd_ready;

  icb_outs_fifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_outs_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_i    (cmd_hs),
    .push_id_i (gnt_id),
    .pop_i     (rsp_hs),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head)
  );

  // A response with nothing outstanding is never accepted nor forwarded.
  assign s_rsp_ready     = ~empty & (head ? m1_icb.rsp_ready : m0_icb.rsp_ready);
  assign rsp_hs          = s_icb.rsp_valid & s_rsp_ready;
  assign s_icb.rsp_ready = s_rsp_ready;

  assign m0_icb.rsp_valid = s_icb.rsp_valid & ~empty & (head == MID_IFU);
  assign m1_icb.rsp_valid = s_icb.rsp_valid & ~empty & (head == MID_LSU);
  assign m0_icb.rsp_rdata = s_icb.rsp_rdata;
  assign m1_icb.rsp_rdata = s_icb.rsp_rdata;
  assign m0_icb.rsp_err   = s_icb.rsp_err;
  assign m1_icb.rsp_err   = s_icb.rsp_err;

  assign dbg_o = '{state: state_q, gnt_vld: gnt_vld, gnt_id: gnt_id, rr_last: rr_last_q};

endmodule

// File: tb/tb_icb_arbt_2m1s.sv
// Directed bench for icb_arbt_2m1s: inputs change on the falling edge,
// outputs are compared 1ns later, well away from the rising edge.
module tb_icb_arbt_2m1s;
  import icb_arbt_2m1s_pkg::*;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] A_T1 = 32'h8000_0010;
  localparam logic [63:0] WD0 = 64'h0000_0000_AAAA_0000;
  localparam logic [63:0] WD1 = 64'h1111_2222_3333_4444;

  // clock/reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  icb_arbt_2m1s_if #(.ADW(ICB_ADW), .DW(ICB_DW)) m0_if ();
  icb_arbt_2m1s_if #(.ADW(ICB_ADW), .DW(ICB_DW)) m1_if ();
  icb_arbt_2m1s_if #(.ADW(ICB_ADW), .DW(ICB_DW)) s_if ();
  arb_dbg_t dbg;

  icb_arbt_2m1s #(.ADW(ICB_ADW), .DW(ICB_DW), .OUTS_DEPTH(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .m0_icb (m0_if),
    .m1_icb (m1_if),
    .s_icb  (s_if),
    .dbg_o  (dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_idle();
    m0_if.cmd_valid = 0; m0_if.cmd_addr = A0; m0_if.cmd_read = 1;
    m0_if.cmd_wdata = WD0; m0_if.cmd_wmask = 8'hFF; m0_if.rsp_ready = 1;
    m1_if.cmd_valid = 0; m1_if.cmd_addr = A1; m1_if.cmd_read = 0;
    m1_if.cmd_wdata = WD1; m1_if.cmd_wmask = 8'hF0; m1_if.rsp_ready = 1;
    s_if.cmd_ready = 1; s_if.rsp_valid = 0; s_if.rsp_rdata = '0; s_if.rsp_err = 0;
  endtask

  task automatic drv_rsp(input logic v, input logic [63:0] d, input logic e);
    s_if.rsp_valid = v; s_if.rsp_rdata = d; s_if.rsp_err = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drv_idle();
    rstn = 0;
    repeat (2) cyc();
    settle();
    chk("rst_s_cmd_valid", s_if.cmd_valid, 0);
    chk("rst_m0_cmd_ready", m0_if.cmd_ready, 0);
    chk("rst_m1_cmd_ready", m1_if.cmd_ready, 0);
    chk("rst_s_rsp_ready", s_if.rsp_ready, 0);
    chk("rst_rsp_valids", {m0_if.rsp_valid, m1_if.rsp_valid}, 0);
    chk("rst_rr_last", dbg.rr_last, 1);
    chk("rst_state", dbg.state, ARB_IDLE);

    // 1: lone m1 write passes straight through
    cyc(); rstn = 1;
    m1_if.cmd_valid = 1; m1_if.cmd_addr = A_T1; m1_if.cmd_wmask = 8'h0F;
    settle();
    chk("t1_s_cmd_valid", s_if.cmd_valid, 1);
    chk("t1_s_addr", s_if.cmd_addr, A_T1);
    chk("t1_s_read", s_if.cmd_read, 0);
    chk("t1_s_wmask", s_if.cmd_wmask, 8'h0F);
    chk("t1_s_wdata", s_if.cmd_wdata, WD1);
    chk("t1_m1_cmd_ready", m1_if.cmd_ready, 1);
    chk("t1_m0_cmd_ready", m0_if.cmd_ready, 0);
    cyc(); m1_if.cmd_valid = 0; m1_if.cmd_addr = A1; m1_if.cmd_wmask = 8'hF0;
    drv_rsp(1, 64'hDEAD_BEEF_0000_0001, 1);
    settle();
    chk("t1_m1_rsp_valid", m1_if.rsp_valid, 1);
    chk("t1_m0_rsp_valid", m0_if.rsp_valid, 0);
    chk("t1_m1_rdata", m1_if.rsp_rdata, 64'hDEAD_BEEF_0000_0001);
    chk("t1_m0_err_fan", m0_if.rsp_err, 1);
    chk("t1_s_rsp_ready", s_if.rsp_ready, 1);
    cyc(); drv_rsp(0, '0, 0);
    settle();
    chk("t1_empty_rsp_ready", s_if.rsp_ready, 0);

    // 2: both request every cycle -> alternating grants, in-order responses
    m0_if.cmd_valid = 1; m1_if.cmd_valid = 1;
    settle();
    chk("t2a_m0_ready", m0_if.cmd_ready, 1);
    chk("t2a_m1_ready", m1_if.cmd_ready, 0);
    chk("t2a_addr", s_if.cmd_addr, A0);
    chk("t2a_read", s_if.cmd_read, 1);
    cyc(); drv_rsp(1, 64'h10, 0);
    settle();
    chk("t2b_m1_ready", m1_if.cmd_ready, 1);
    chk("t2b_addr", s_if.cmd_addr, A1);
    chk("t2b_rsp_to_m0", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b10);
    cyc(); drv_rsp(1, 64'h11, 0);
    settle();
    chk("t2c_m0_ready", m0_if.cmd_ready, 1);
    chk("t2c_addr", s_if.cmd_addr, A0);
    chk("t2c_rsp_to_m1", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b01);
    cyc(); drv_rsp(1, 64'h12, 0);
    settle();
    chk("t2d_m1_ready", m1_if.cmd_ready, 1);
    chk("t2d_rsp_to_m0", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b10);
    chk("t2d_m0_rdata", m0_if.rsp_rdata, 64'h12);
    cyc(); m0_if.cmd_valid = 0; m1_if.cmd_valid = 0; drv_rsp(1, 64'h13, 0);
    settle();
    chk("t2e_rsp_to_m1", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b01);
    chk("t2e_s_cmd_valid", s_if.cmd_valid, 0);

    // 3: m1 stalled by slave, m0 joins -> grant locked on m1
    cyc(); drv_rsp(0, '0, 0);
    m1_if.cmd_valid = 1; s_if.cmd_ready = 0;
    settle();
    chk("t3c1_s_cmd_valid", s_if.cmd_valid, 1);
    chk("t3c1_m1_ready", m1_if.cmd_ready, 0);
    chk("t3c1_rsp_ready", s_if.rsp_ready, 0);
    cyc(); m0_if.cmd_valid = 1;
    settle();
    chk("t3c2_state", dbg.state, ARB_LOCK);
    chk("t3c2_addr", s_if.cmd_addr, A1);
    chk("t3c2_m0_ready", m0_if.cmd_ready, 0);
    cyc();
    settle();
    chk("t3c3_addr", s_if.cmd_addr, A1);
    chk("t3c3_wdata", s_if.cmd_wdata, WD1);
    cyc(); s_if.cmd_ready = 1;
    settle();
    chk("t3c4_m1_ready", m1_if.cmd_ready, 1);
    chk("t3c4_m0_ready", m0_if.cmd_ready, 0);
    cyc(); m1_if.cmd_valid = 0;
    settle();
    chk("t3c5_state", dbg.state, ARB_IDLE);
    chk("t3c5_m0_ready", m0_if.cmd_ready, 1);
    chk("t3c5_addr", s_if.cmd_addr, A0);

    // 4: two outstanding -> blocked; a pop frees a slot only the next cycle
    cyc(); m1_if.cmd_valid = 1;
    settle();
    chk("t4_full_s_valid", s_if.cmd_valid, 0);
    chk("t4_full_readys", {m0_if.cmd_ready, m1_if.cmd_ready}, 2'b00);
    cyc(); drv_rsp(1, 64'h20, 0);
    settle();
    chk("t4_pop_m1_rsp", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b01);
    chk("t4_no_bypass", s_if.cmd_valid, 0);
    cyc(); drv_rsp(0, '0, 0);
    settle();
    chk("t4_after_pop_m1_ready", m1_if.cmd_ready, 1);
    chk("t4_after_pop_m0_ready", m0_if.cmd_ready, 0);

    // 5: head m0 back-pressures, m1 response waits behind it
    cyc(); m0_if.cmd_valid = 0; m1_if.cmd_valid = 0;
    m0_if.rsp_ready = 0; drv_rsp(1, 64'h30, 0);
    settle();
    chk("t5a_rsp_valids", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b10);
    chk("t5a_s_rsp_ready", s_if.rsp_ready, 0);
    cyc();
    settle();
    chk("t5b_s_rsp_ready", s_if.rsp_ready, 0);
    chk("t5b_m0_rdata", m0_if.rsp_rdata, 64'h30);
    cyc(); m0_if.rsp_ready = 1;
    settle();
    chk("t5c_s_rsp_ready", s_if.rsp_ready, 1);
    cyc(); drv_rsp(0, '0, 0); m0_if.cmd_valid = 1;
    settle();
    chk("t5d_m0_ready", m0_if.cmd_ready, 1);

    // 6: reset with two outstanding discards them; stray response ignored
    cyc(); m0_if.cmd_valid = 0; rstn = 0;
    cyc(); rstn = 1; drv_rsp(1, 64'h40, 0);
    settle();
    chk("t6_stray_rsp_ready", s_if.rsp_ready, 0);
    chk("t6_stray_rsp_valids", {m0_if.rsp_valid, m1_if.rsp_valid}, 2'b00);
    chk("t6_rr_last", dbg.rr_last, 1);
    cyc(); drv_rsp(0, '0, 0); m0_if.cmd_valid = 1; m1_if.cmd_valid = 1;
    settle();
    chk("t6_first_m0_ready", m0_if.cmd_ready, 1);
    cyc();
    settle();
    chk("t6_second_m1_ready", m1_if.cmd_ready, 1);
    cyc();
    settle();
    chk("t6_third_blocked", s_if.cmd_valid, 0);
    cyc(); drv_idle();

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
